slow_sched: RTL and testbench

- Scheduler that decides when the accelerated CPU must drop to stock-Mac bus timing.
- Sits between the address decoder and the fast/slow clock switch.
- Compares each bus cycle against the per-device slow-enable configuration bits.
- Holds slow mode for a programmable timeout after the last matching access, then releases it.
- Also drives the fast-clock gate request while slow mode is active.

---
 rtl/slow_sched_pkg.sv | 24 ++
 rtl/slow_hold_cnt.sv | 35 +++
 rtl/slow_sched.sv | 112 +++++++++++
 tb/tb_slow_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_sched_pkg.sv
// Shared definitions for the slow-timing scheduler.
//   slow_state_t     : scheduler FSM state encoding
//   HOLD_UNIT_LOG2   : log2 of the hold granularity in Tick pulses
//   DEF_*            : power-on configuration values for the enable/timeout registers
package slow_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } slow_state_t;

  localparam int unsigned HOLD_UNIT_LOG2 = 4;

  localparam logic [3:0] DEF_SLOW_TIMEOUT    = 4'hF;
  localparam logic       DEF_SLOW_IACK       = 1'b0;
  localparam logic       DEF_SLOW_VIA        = 1'b1;
  localparam logic       DEF_SLOW_IWM        = 1'b1;
  localparam logic       DEF_SLOW_SCC        = 1'b1;
  localparam logic       DEF_SLOW_SCSI       = 1'b1;
  localparam logic       DEF_SLOW_SND        = 1'b1;
  localparam logic       DEF_SLOW_CLOCK_GATE = 1'b0;

endpackage

// File: rtl/slow_hold_cnt.sv
// Loadable down-counter measuring the slow-mode hold time in Tick pulses.
//   CLK, nPOR : clock, asynchronous active-low reset (counter clears to 0)
//   load      : load loadVal (has priority over dec)
//   loadVal   : value to load
//   dec       : decrement by one; saturates at zero, never wraps
//   isZero    : counter is zero
//   isOne     : counter is one (the next decrement expires the hold)
module slow_hold_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             nPOR,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             isZero,
  output logic             isOne
);

  logic [CNT_W-1:0] cntQ;

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      cntQ <= '0;
    end else if (load) begin
      cntQ <= loadVal;
    end else if (dec && (cntQ != '0)) begin
      cntQ <= cntQ - CNT_W'(1);
    end
  end

  assign isZero = (cntQ == '0);
  assign isOne  = (cntQ == CNT_W'(1));

endmodule

// File: rtl/slow_sched.sv
// Decides when the accelerated CPU must drop to stock bus timing. A bus cycle that hits a
// device with its slow-enable set forces slow mode for the whole access, then holds it for
// SlowTimeout*16 Tick pulses after BACT falls. All outputs are registered from next state.
//   CLK, nPOR              : clock, asynchronous active-low reset
//   BACT                   : bus cycle active
//   IACKCS..SndCS          : device decodes for the current bus cycle
//   SlowIACK..SlowSnd      : per-device slow enables (sampled live)
//   SlowClockGate          : allow fast-clock gating while slow
//   SlowTimeout            : hold length in units of 16 Ticks (0 = no hold)
//   Tick                   : one-CLK timebase pulse
//   Slow, SlowAccess       : slow mode active / matching access in progress
//   ClockGate              : gate the fast clock
module slow_sched
  import slow_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  input  logic       Tick,
  output logic       Slow,
  output logic       SlowAccess,
  output logic       ClockGate
);

  slow_state_t      stateQ, stateD;
  logic             match, start;
  logic             cntLoad, cntDec, cntZero, cntOne;
  logic [CNT_W-1:0] loadVal;
  logic             slowQ, slowAccessQ, clockGateQ;

  assign match = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                 (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);
  assign start = BACT & match;

  assign loadVal = CNT_W'({SlowTimeout, {HOLD_UNIT_LOG2{1'b0}}});

  always_comb begin
    stateD  = stateQ;
    cntLoad = 1'b0;
    cntDec  = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (start) stateD = ACCESS;
      end
      ACCESS: begin
        if (!BACT) begin
          cntLoad = 1'b1;
          stateD  = (SlowTimeout == 4'd0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        // A new matching access wins over a coincident Tick; the count is discarded.
        if (start) begin
          stateD = ACCESS;
        end else if (cntZero) begin
          stateD = IDLE;  // unreachable in normal operation; never stall in HOLD
        end else if (Tick) begin
          cntDec = 1'b1;
          if (cntOne) stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      stateQ      <= IDLE;
      slowQ       <= 1'b0;
      slowAccessQ <= 1'b0;
      clockGateQ  <= 1'b0;
    end else begin
      stateQ      <= stateD;
      slowQ       <= (stateD != IDLE);
      slowAccessQ <= (stateD == ACCESS);
      clockGateQ  <= (stateD != IDLE) & SlowClockGate;
    end
  end

  assign Slow       = slowQ;
  assign SlowAccess = slowAccessQ;
  assign ClockGate  = clockGateQ;

  slow_hold_cnt #(
    .CNT_W(CNT_W)
  ) u_hold_cnt (
    .CLK    (CLK),
    .nPOR   (nPOR),
    .load   (cntLoad),
    .loadVal(loadVal),
    .dec    (cntDec),
    .isZero (cntZero),
    .isOne  (cntOne)
  );

endmodule

// File: tb/tb_slow_sched.sv
// Self-checking bench for slow_sched: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_slow_sched;
  import slow_sched_pkg::*;

  logic       CLK = 1'b0;
  logic       nPOR = 1'b0;
  logic       BACT = 1'b0;
  logic       IACKCS = 1'b0, VIACS = 1'b0, IWMCS = 1'b0, SCCCS = 1'b0, SCSICS = 1'b0;
  logic       SndCS = 1'b0;
  logic       SlowIACK = DEF_SLOW_IACK, SlowVIA = DEF_SLOW_VIA, SlowIWM = DEF_SLOW_IWM;
  logic       SlowSCC = DEF_SLOW_SCC, SlowSCSI = DEF_SLOW_SCSI, SlowSnd = DEF_SLOW_SND;
  logic       SlowClockGate = DEF_SLOW_CLOCK_GATE;
  logic [3:0] SlowTimeout = DEF_SLOW_TIMEOUT;
  logic       Tick = 1'b0;
  logic       Slow, SlowAccess, ClockGate;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  slow_sched #(
    .CNT_W(8)
  ) dut (
    .CLK          (CLK),
    .nPOR         (nPOR),
    .BACT         (BACT),
    .IACKCS       (IACKCS),
    .VIACS        (VIACS),
    .IWMCS        (IWMCS),
    .SCCCS        (SCCCS),
    .SCSICS       (SCSICS),
    .SndCS        (SndCS),
    .SlowIACK     (SlowIACK),
    .SlowVIA      (SlowVIA),
    .SlowIWM      (SlowIWM),
    .SlowSCC      (SlowSCC),
    .SlowSCSI     (SlowSCSI),
    .SlowSnd      (SlowSnd),
    .SlowClockGate(SlowClockGate),
    .SlowTimeout  (SlowTimeout),
    .Tick         (Tick),
    .Slow         (Slow),
    .SlowAccess   (SlowAccess),
    .ClockGate    (ClockGate)
  );

  // Behavioural model: slow flag, access flag, and Ticks still owed before release.
  bit m_slow, m_acc, m_cg;
  int m_rem;

  function automatic bit model_start();
    return BACT && ((IACKCS && SlowIACK) || (VIACS && SlowVIA) || (IWMCS && SlowIWM) ||
                    (SCCCS && SlowSCC) || (SCSICS && SlowSCSI) || (SndCS && SlowSnd));
  endfunction

  always @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      m_slow <= 1'b0;
      m_acc  <= 1'b0;
      m_cg   <= 1'b0;
      m_rem  <= 0;
    end else begin
      m_cg <= SlowClockGate;
      if (!m_slow) begin
        if (model_start()) begin
          m_slow <= 1'b1;
          m_acc  <= 1'b1;
        end
      end else if (m_acc) begin
        if (!BACT) begin
          m_acc  <= 1'b0;
          m_rem  <= int'(SlowTimeout) * 16;
          m_slow <= (SlowTimeout != 4'd0);
        end
      end else if (model_start()) begin
        m_acc <= 1'b1;
      end else if (Tick) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_slow <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      n_vec++;
      if ({Slow, SlowAccess, ClockGate} !== {m_slow, m_acc, m_slow & m_cg}) begin
        n_bad++;
        $display("FAIL cycle t=%0t got Slow/Acc/Gate=%b%b%b want %b%b%b", $time, Slow,
                 SlowAccess, ClockGate, m_slow, m_acc, m_slow & m_cg);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic bus_idle();
    BACT   = 1'b0;
    IACKCS = 1'b0;
    VIACS  = 1'b0;
    IWMCS  = 1'b0;
    SCCCS  = 1'b0;
    SCSICS = 1'b0;
    SndCS  = 1'b0;
  endtask

  // Issue Ticks every 'gap' cycles until Slow drops; returns ticks issued, -1 if it never drops.
  task automatic count_ticks(input int gap, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      Tick = 1'b1;
      @(negedge CLK);
      Tick = 1'b0;
      if (!Slow) begin
        n = i;
        break;
      end
      repeat (gap - 1) @(negedge CLK);
    end
  endtask

  task automatic ticks(input int num, input int gap);
    for (int i = 0; i < num; i++) begin
      Tick = 1'b1;
      @(negedge CLK);
      Tick = 1'b0;
      repeat (gap - 1) @(negedge CLK);
    end
  endtask

  int n;

  initial begin
    // Reset held with a matching access present.
    SlowTimeout   = 4'h0;
    SlowClockGate = 1'b1;
    BACT          = 1'b1;
    VIACS         = 1'b1;
    SlowVIA       = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset Slow", Slow, 0);
    chk("reset SlowAccess", SlowAccess, 0);
    chk("reset ClockGate", ClockGate, 0);
    #2 nPOR = 1'b1;
    @(negedge CLK);
    chk("post-reset Slow", Slow, 1);
    chk("post-reset SlowAccess", SlowAccess, 1);
    chk("post-reset ClockGate", ClockGate, 1);
    bus_idle();
    @(negedge CLK);
    chk("post-reset release", Slow, 0);

    // Basic hold: 2*16 Ticks, one every 4 CLK.
    SlowTimeout = 4'h2;
    BACT = 1'b1;
    VIACS = 1'b1;
    repeat (3) @(negedge CLK);
    chk("basic access SlowAccess", SlowAccess, 1);
    bus_idle();
    @(negedge CLK);
    chk("basic hold SlowAccess", SlowAccess, 0);
    chk("basic hold ClockGate", ClockGate, 1);
    count_ticks(4, 100, n);
    chk("basic hold tick count", n, 32);
    chk("basic ClockGate released", ClockGate, 0);

    // Zero timeout: no hold at all.
    SlowTimeout = 4'h0;
    BACT = 1'b1;
    SCCCS = 1'b1;
    @(negedge CLK);
    chk("zero-to access", SlowAccess, 1);
    @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    chk("zero-to Slow", Slow, 0);

    // Retrigger with a coincident Tick.
    SlowTimeout = 4'h1;
    BACT = 1'b1;
    IWMCS = 1'b1;
    repeat (2) @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    ticks(10, 2);
    chk("model pin rem after 10", m_rem, 6);
    BACT = 1'b1;
    IWMCS = 1'b1;
    Tick = 1'b1;
    @(negedge CLK);
    Tick = 1'b0;
    chk("retrigger SlowAccess", SlowAccess, 1);
    @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    count_ticks(2, 40, n);
    chk("retrigger tick count", n, 16);

    // Masked devices never go slow.
    SlowSCSI = 1'b0;
    SlowIACK = 1'b0;
    BACT = 1'b1;
    SCSICS = 1'b1;
    repeat (3) @(negedge CLK);
    chk("masked SCSI", Slow, 0);
    SCSICS = 1'b0;
    IACKCS = 1'b1;
    repeat (3) @(negedge CLK);
    chk("masked IACK", Slow, 0);
    bus_idle();
    // Non-matching cycle during HOLD leaves the count alone.
    BACT = 1'b1;
    VIACS = 1'b1;
    repeat (2) @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    ticks(5, 2);
    BACT = 1'b1;
    SCSICS = 1'b1;
    repeat (3) @(negedge CLK);
    chk("non-match hold SlowAccess", SlowAccess, 0);
    chk("non-match hold Slow", Slow, 1);
    bus_idle();
    @(negedge CLK);
    count_ticks(2, 40, n);
    chk("non-match remaining ticks", n, 11);

    // Asynchronous reset mid-hold at count 100.
    SlowTimeout = 4'hF;
    BACT = 1'b1;
    VIACS = 1'b1;
    repeat (2) @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    Tick = 1'b1;
    repeat (140) @(negedge CLK);
    Tick = 1'b0;
    chk("model pin rem 100", m_rem, 100);
    chk("pre-reset Slow", Slow, 1);
    @(posedge CLK);
    #2 nPOR = 1'b0;
    #1;
    chk("async reset Slow", Slow, 0);
    chk("async reset SlowAccess", SlowAccess, 0);
    chk("async reset ClockGate", ClockGate, 0);
    @(negedge CLK);
    #3 nPOR = 1'b1;
    repeat (2) @(negedge CLK);
    chk("after reset idle", Slow, 0);
    SlowTimeout = 4'h1;
    BACT = 1'b1;
    VIACS = 1'b1;
    @(negedge CLK);
    bus_idle();
    @(negedge CLK);
    count_ticks(1, 40, n);
    chk("after reset fresh hold", n, 16);

    // Randomized phase; the per-cycle compare does the checking.
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 5) == 0) BACT = ~BACT;
      IACKCS = ($urandom_range(0, 3) == 0);
      VIACS  = ($urandom_range(0, 3) == 0);
      IWMCS  = ($urandom_range(0, 3) == 0);
      SCCCS  = ($urandom_range(0, 3) == 0);
      SCSICS = ($urandom_range(0, 3) == 0);
      SndCS  = ($urandom_range(0, 3) == 0);
      Tick   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) begin
        SlowIACK      = 1'($urandom_range(0, 1));
        SlowVIA       = 1'($urandom_range(0, 1));
        SlowIWM       = 1'($urandom_range(0, 1));
        SlowSCC       = 1'($urandom_range(0, 1));
        SlowSCSI      = 1'($urandom_range(0, 1));
        SlowSnd       = 1'($urandom_range(0, 1));
        SlowClockGate = 1'($urandom_range(0, 1));
        SlowTimeout   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 nPOR = 1'b0;
        #2 nPOR = 1'b1;
      end
    end
    Tick = 1'b0;
    bus_idle();
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
